// File: rtl/qm_writeback_pkg.sv
// Shared widths and types for the writeback slice: register/data widths,
// the queued-result entry layout and the write-port source encoding.
package qm_writeback_pkg;

  localparam int QM_REG_W  = 5;
  localparam int QM_DATA_W = 32;
  localparam logic [QM_REG_W-1:0] QM_REG_ZERO = '0;

  typedef struct packed {
    logic [QM_REG_W-1:0]  wa;
    logic [QM_DATA_W-1:0] wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FIFO = 2'd1,
    SRC_EX   = 2'd2,
    SRC_LU   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/qm_writeback_if.sv
// Bundle of result streams, hazard queries and the register-file write port
// seen by the writeback stage.
interface qm_writeback_if;
  import qm_writeback_pkg::*;

  logic                 ex_valid;
  logic [QM_REG_W-1:0]  ex_wa;
  logic [QM_DATA_W-1:0] ex_wd;
  logic                 ex_stall;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [QM_REG_W-1:0]  lu_wa;
  logic [QM_DATA_W-1:0] lu_wd;
  logic                 iss_valid;
  logic [QM_REG_W-1:0]  iss_wa;
  logic [QM_REG_W-1:0]  ra1;
  logic [QM_REG_W-1:0]  ra2;
  logic                 busy1;
  logic                 busy2;
  logic                 fwd1_hit;
  logic                 fwd2_hit;
  logic [QM_DATA_W-1:0] fwd1_data;
  logic [QM_DATA_W-1:0] fwd2_data;
  logic                 we3;
  logic [QM_REG_W-1:0]  wa3;
  logic [QM_DATA_W-1:0] wd3;

  modport slave (
    input  ex_valid, ex_wa, ex_wd, lu_valid, lu_wa, lu_wd,
           iss_valid, iss_wa, ra1, ra2,
    output ex_stall, lu_ready, busy1, busy2, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, we3, wa3, wd3
  );

  modport master (
    output ex_valid, ex_wa, ex_wd, lu_valid, lu_wa, lu_wd,
           iss_valid, iss_wa, ra1, ra2,
    input  ex_stall, lu_ready, busy1, busy2, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, we3, wa3, wd3
  );

endinterface

// File: rtl/qm_wb_fifo.sv
// Small synchronous FIFO for long-latency results; a push into a full FIFO is
// accepted only when the head is popped in the same cycle.
module qm_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qm_writeback.sv
// Register-file writer: merges in-order and long-latency results onto the
// single write port, tracks pending long-latency destinations, bypasses wd3.
module qm_writeback
  import qm_writeback_pkg::*;
#(
  parameter int LU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  qm_writeback_if.slave   wb
);

  localparam int CNT_W = $clog2(LU_DEPTH) + 1;

  wb_entry_t            ex_in;
  wb_entry_t            lu_in;
  wb_entry_t            fifo_head;
  wb_entry_t            sel_p0;
  wb_src_e              src_p0;
  logic                 sel_vld_p0;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 lu_xfer;
  logic [31:0]          sb_q;
  logic [31:0]          sb_set;
  logic [31:0]          sb_clr;
  logic                 we3_q;
  logic [QM_REG_W-1:0]  wa3_q;
  logic [QM_DATA_W-1:0] wd3_q;

  assign ex_in = '{wa: wb.ex_wa, wd: wb.ex_wd};
  assign lu_in = '{wa: wb.lu_wa, wd: wb.lu_wd};

  qm_wb_fifo #(
    .DEPTH (LU_DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lu_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO always drains its head, so the long-latency side can pass through.
  assign wb.lu_ready = rst_n && ((fifo_count != CNT_W'(LU_DEPTH)) || fifo_pop);
  assign wb.ex_stall = rst_n && wb.ex_valid && fifo_full;
  assign lu_xfer     = wb.lu_valid && wb.lu_ready;

  // p0: pick this cycle's write-port source
  always_comb begin
    src_p0    = SRC_NONE;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (fifo_full) begin
      src_p0    = SRC_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = lu_xfer;
    end else if (wb.ex_valid) begin
      src_p0    = SRC_EX;
      fifo_push = lu_xfer;
    end else if (!fifo_empty) begin
      src_p0    = SRC_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = lu_xfer;
    end else if (lu_xfer) begin
      src_p0    = SRC_LU;
    end
  end

  always_comb begin
    sel_p0     = '0;
    sel_vld_p0 = 1'b1;
    unique case (src_p0)
      SRC_FIFO: sel_p0 = fifo_head;
      SRC_EX:   sel_p0 = ex_in;
      SRC_LU:   sel_p0 = lu_in;
      default:  sel_vld_p0 = 1'b0;
    endcase
  end

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (wb.iss_valid && (wb.iss_wa != QM_REG_ZERO))
      sb_set = 32'd1 << wb.iss_wa;
    if (((src_p0 == SRC_FIFO) || (src_p0 == SRC_LU)) && (sel_p0.wa != QM_REG_ZERO))
      sb_clr = 32'd1 << sel_p0.wa;
  end

  // p1: write-port registers and scoreboard; a same-cycle re-issue keeps the bit set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
      sb_q  <= '0;
    end else begin
      we3_q <= sel_vld_p0 && (sel_p0.wa != QM_REG_ZERO);
      if (sel_vld_p0) begin
        wa3_q <= sel_p0.wa;
        wd3_q <= sel_p0.wd;
      end
      sb_q <= (sb_q & ~sb_clr) | sb_set;
    end
  end

  assign wb.we3 = we3_q;
  assign wb.wa3 = wa3_q;
  assign wb.wd3 = wd3_q;

  assign wb.busy1 = (wb.ra1 != QM_REG_ZERO) && sb_q[wb.ra1];
  assign wb.busy2 = (wb.ra2 != QM_REG_ZERO) && sb_q[wb.ra2];

  assign wb.fwd1_hit  = we3_q && (wa3_q != QM_REG_ZERO) && (wb.ra1 == wa3_q);
  assign wb.fwd2_hit  = we3_q && (wa3_q != QM_REG_ZERO) && (wb.ra2 == wa3_q);
  assign wb.fwd1_data = wb.fwd1_hit ? wd3_q : '0;
  assign wb.fwd2_data = wb.fwd2_hit ? wd3_q : '0;

endmodule
